// File: rtl/tdm_pkg.sv
// Shared constants and state type for the c4/f0 TDM link (master and converter benches).
package tdm_pkg;

  localparam int TDM_C4_HALF  = 6;
  localparam int TDM_BITS     = 32;
  localparam int TDM_FRAME_C4 = 66;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/c4_clock_gen.sv
// Divides clk50 down to the c4 bit clock and flags the cycle before each c4 edge.
module c4_clock_gen #(
  parameter int C4_HALF = 6
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_c4,
  output logic o_rise,
  output logic o_fall
);

  localparam int DW = (C4_HALF > 1) ? $clog2(C4_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(C4_HALF - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  logic [DW-1:0] r_div;
  logic          r_c4;
  logic          w_wrap;

  assign w_wrap = i_run && (r_div == DIV_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run) begin
      r_div <= '0;
      r_c4  <= 1'b0;
    end else if (w_wrap) begin
      r_div <= '0;
      r_c4  <= ~r_c4;
    end else begin
      r_div <= r_div + DIV_ONE;
    end
  end

  // Events mark the cycle whose closing edge moves c4, so inputs seen here are pre-edge.
  assign o_c4   = r_c4;
  assign o_rise = w_wrap & ~r_c4;
  assign o_fall = w_wrap &  r_c4;

endmodule

// File: rtl/tdm_frame_master.sv
// Master end of the c4/f0 TDM link: framing, LSB-first tx/rx shifters and tx holding register.
module tdm_frame_master
  import tdm_pkg::*;
#(
  parameter int                        C4_HALF        = TDM_C4_HALF,
  parameter int                        BITS_PER_FRAME = TDM_BITS,
  parameter int                        FRAME_C4       = TDM_FRAME_C4,
  parameter logic [BITS_PER_FRAME-1:0] IDLE_WORD      = '0
) (
  input  logic                      clk50,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [BITS_PER_FRAME-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [BITS_PER_FRAME-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      frame_start,
  output logic                      tx_underrun,
  output logic                      c4,
  output logic                      f0,
  output logic                      data_to_conv,
  input  logic                      data_from_conv
);

  localparam int RW = $clog2(FRAME_C4);
  localparam logic [RW-1:0] R_LAST     = RW'(FRAME_C4 - 1);
  localparam logic [RW-1:0] R_ONE      = RW'(1);
  localparam logic [RW-1:0] R_RX_FIRST = RW'(2);
  localparam logic [RW-1:0] R_RX_LAST  = RW'(2 * BITS_PER_FRAME);
  localparam logic [RW-1:0] R_TX_LAST  = RW'(2 * BITS_PER_FRAME - 1);

  tdm_state_e r_state, w_state_nxt;

  logic w_run, w_c4, w_rise, w_fall;
  logic w_bnd, w_accept, w_tx_slot, w_rx_slot, w_rx_done;

  logic [RW-1:0]             r_rise_idx;
  logic                      r_lead;
  logic                      r_f0, r_dout;
  logic                      r_frame_start, r_underrun, r_rx_valid, r_tx_ready;
  logic [BITS_PER_FRAME-1:0] r_rx_data, r_hold, r_tx_sh;
  logic [BITS_PER_FRAME-2:0] r_rx_sh;

  c4_clock_gen #(
    .C4_HALF (C4_HALF)
  ) u_c4_gen (
    .i_clk  (clk50),
    .i_rst  (reset),
    .i_run  (w_run),
    .o_c4   (w_c4),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_ff @(posedge clk50) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_nxt = RUN;
      RUN:     if (w_fall && !enable) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_rise_idx is the index the next c4 rise will carry.
  assign w_run     = (r_state == RUN);
  assign w_bnd     = w_fall & enable & (r_rise_idx == '0);
  assign w_accept  = tx_valid & r_tx_ready;
  assign w_tx_slot = r_rise_idx[0] & (r_rise_idx <= R_TX_LAST);
  assign w_rx_slot = ~r_rise_idx[0] & (r_rise_idx >= R_RX_FIRST) & (r_rise_idx <= R_RX_LAST);
  assign w_rx_done = w_rise & (r_rise_idx == R_RX_LAST);

  always_ff @(posedge clk50) begin
    if (reset) begin
      r_rise_idx    <= '0;
      r_lead        <= 1'b1;
      r_f0          <= 1'b1;
      r_dout        <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_rx_data     <= '0;
      r_tx_ready    <= 1'b1;
    end else begin
      r_frame_start <= w_bnd;
      r_underrun    <= w_bnd & r_tx_ready;
      r_rx_valid    <= w_rx_done;
      if (w_rx_done) r_rx_data <= {data_from_conv, r_rx_sh};
      if (w_bnd)         r_tx_ready <= ~w_accept;
      else if (w_accept) r_tx_ready <= 1'b0;
      if (!w_run) begin
        r_rise_idx <= '0;
        r_lead     <= 1'b1;
        r_f0       <= 1'b1;
        r_dout     <= 1'b0;
      end else begin
        // The rise before the very first fall is a lead-in and carries no index.
        if (w_rise && !r_lead)
          r_rise_idx <= (r_rise_idx == R_LAST) ? '0 : r_rise_idx + R_ONE;
        if (w_fall) begin
          r_lead <= 1'b0;
          if (!enable) begin
            r_f0   <= 1'b1;
            r_dout <= 1'b0;
          end else begin
            r_f0 <= (r_rise_idx != '0);
            if (w_tx_slot) r_dout <= r_tx_sh[0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (w_accept) r_hold <= tx_data;
    if (w_bnd)                     r_tx_sh <= r_tx_ready ? IDLE_WORD : r_hold;
    else if (w_fall && w_tx_slot)  r_tx_sh <= r_tx_sh >> 1;
    if (w_rise && w_rx_slot) r_rx_sh <= {data_from_conv, r_rx_sh[BITS_PER_FRAME-2:1]};
  end

  assign c4           = w_c4;
  assign f0           = r_f0;
  assign data_to_conv = r_dout;
  assign tx_ready     = r_tx_ready;
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign frame_start  = r_frame_start;
  assign tx_underrun  = r_underrun;

endmodule

// File: tb/tb_tdm_frame_master.sv
// Directed bench for tdm_frame_master with a one-c4-period loopback model of the converter.
module tb_tdm_frame_master;
  import tdm_pkg::*;

  localparam int HALF      = TDM_C4_HALF;
  localparam int BITS      = TDM_BITS;
  localparam int FRAME     = TDM_FRAME_C4;
  localparam int FRAME_CYC = FRAME * 2 * HALF;
  localparam logic [31:0] IDLE_W = 32'h0000_0000;
  localparam logic [31:0] W_A    = 32'hA5C3_0F81;
  localparam logic [31:0] W_1    = 32'h1234_5678;
  localparam logic [31:0] W_2    = 32'hFEDC_BA98;

  logic        clk50 = 1'b0;
  logic        reset, enable, tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready, rx_valid, frame_start, tx_underrun, c4, f0, data_to_conv;
  logic [31:0] rx_data;
  logic        data_from_conv;
  logic        model_q = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_tx, cap_rx;
  int          cap_rxv, cap_und, cap_nrdy, cap_cyc;

  always #5 clk50 = ~clk50;

  always @(posedge c4) model_q <= data_to_conv;
  assign data_from_conv = model_q;

  tdm_frame_master #(
    .C4_HALF        (HALF),
    .BITS_PER_FRAME (BITS),
    .FRAME_C4       (FRAME),
    .IDLE_WORD      (IDLE_W)
  ) dut (
    .clk50          (clk50),
    .reset          (reset),
    .enable         (enable),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .frame_start    (frame_start),
    .tx_underrun    (tx_underrun),
    .c4             (c4),
    .f0             (f0),
    .data_to_conv   (data_to_conv),
    .data_from_conv (data_from_conv)
  );

  // Observes one frame up to (not including) the next frame_start cycle.
  task automatic capture_frame();
    int  k;
    int  n;
    logic pc;
    cap_tx = '0; cap_rx = '0; cap_rxv = 0; cap_und = 0; cap_nrdy = 0; cap_cyc = 0;
    k = 0; n = 0; pc = c4;
    forever begin
      @(negedge clk50);
      n++;
      if (frame_start) break;
      if (n > 2 * FRAME_CYC) begin
        errors++;
        $display("FAIL capture_timeout: no frame_start within %0d cycles", 2 * FRAME_CYC);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "frame_start timeout");
      end
      cap_cyc++;
      if (c4 && !pc) begin
        if ((k % 2) == 1 && k < 2 * BITS) cap_tx[k / 2] = data_to_conv;
        k++;
      end
      pc = c4;
      if (rx_valid) begin cap_rxv++; cap_rx = rx_data; end
      if (tx_underrun) cap_und++;
      if (!tx_ready) cap_nrdy++;
    end
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk50);
    checks++; if (c4 !== 1'b0) begin errors++; $display("FAIL rst_c4: got %b want 0", c4); end
    checks++; if (f0 !== 1'b1) begin errors++; $display("FAIL rst_f0: got %b want 1", f0); end
    checks++; if (data_to_conv !== 1'b0) begin errors++; $display("FAIL rst_dout: got %b want 0", data_to_conv); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
    checks++; if (rx_data !== 32'h0) begin errors++; $display("FAIL rst_rx_data: got %h want 0", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start: got %b want 0", frame_start); end
    checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b want 0", tx_underrun); end
  endtask

  task automatic test_framing();
    int n, last, bad, edges, f0low;
    logic pc;
    reset = 1'b0; enable = 1'b1;
    n = 0;
    do begin @(negedge clk50); n++; end while (!frame_start && n < 100);
    checks++; if (n !== 2 * HALF + 1) begin errors++; $display("FAIL first_fs_delay: got %0d want %0d", n, 2 * HALF + 1); end
    checks++; if (f0 !== 1'b0) begin errors++; $display("FAIL f0_low_at_fs: got %b want 0", f0); end
    n = 0; last = 0; bad = 0; edges = 0; f0low = 1; pc = c4;
    do begin
      @(negedge clk50); n++;
      if (c4 !== pc) begin
        if (n - last != HALF) bad++;
        last = n; pc = c4; edges++;
      end
      if (f0 == 1'b0 && !frame_start) f0low++;
    end while (!frame_start && n < 2 * FRAME_CYC);
    checks++; if (n !== FRAME_CYC) begin errors++; $display("FAIL frame_period: got %0d want %0d", n, FRAME_CYC); end
    checks++; if (f0low !== 2 * HALF) begin errors++; $display("FAIL f0_low_len: got %0d want %0d", f0low, 2 * HALF); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL c4_half_period: got %0d bad intervals want 0", bad); end
    checks++; if (edges !== 2 * FRAME) begin errors++; $display("FAIL c4_edges: got %0d want %0d", edges, 2 * FRAME); end
  endtask

  task automatic test_tx_loopback();
    tx_data = W_A; tx_valid = 1'b1;
    @(negedge clk50);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL tx_ready_full: got %b want 0", tx_ready); end
    tx_valid = 1'b0;
    capture_frame();
    checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL underrun_with_word: got %b want 0", tx_underrun); end
    capture_frame();
    checks++; if (cap_tx !== W_A) begin errors++; $display("FAIL tx_bits: got %h want %h", cap_tx, W_A); end
    checks++; if (cap_rxv !== 1) begin errors++; $display("FAIL rx_valid_count: got %0d want 1", cap_rxv); end
    checks++; if (cap_rx !== W_A) begin errors++; $display("FAIL rx_word: got %h want %h", cap_rx, W_A); end
    checks++; if (cap_nrdy !== 0) begin errors++; $display("FAIL tx_ready_after_load: got %0d low cycles want 0", cap_nrdy); end
  endtask

  task automatic test_underrun();
    int total;
    total = (tx_underrun === 1'b1) ? 1 : 0;
    capture_frame();
    total += cap_und;
    checks++; if (total !== 1) begin errors++; $display("FAIL underrun_pulses: got %0d want 1", total); end
    checks++; if (cap_tx !== IDLE_W) begin errors++; $display("FAIL idle_word_bits: got %h want %h", cap_tx, IDLE_W); end
    checks++; if (cap_nrdy !== 0) begin errors++; $display("FAIL idle_tx_ready: got %0d low cycles want 0", cap_nrdy); end
    checks++; if (cap_rx !== IDLE_W) begin errors++; $display("FAIL idle_rx_word: got %h want %h", cap_rx, IDLE_W); end
  endtask

  task automatic test_back_to_back();
    tx_data = W_1; tx_valid = 1'b1;
    @(negedge clk50);
    tx_data = W_2;
    capture_frame();
    checks++; if (cap_nrdy !== cap_cyc) begin errors++; $display("FAIL b2b_stall: got %0d of %0d cycles not ready", cap_nrdy, cap_cyc); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_fs: got %b want 1", tx_ready); end
    checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL b2b_underrun1: got %b want 0", tx_underrun); end
    @(negedge clk50);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got %b want 0", tx_ready); end
    tx_valid = 1'b0;
    capture_frame();
    checks++; if (cap_tx !== W_1) begin errors++; $display("FAIL b2b_word1: got %h want %h", cap_tx, W_1); end
    checks++; if (cap_rx !== W_1) begin errors++; $display("FAIL b2b_rx1: got %h want %h", cap_rx, W_1); end
    checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL b2b_underrun2: got %b want 0", tx_underrun); end
    capture_frame();
    checks++; if (cap_tx !== W_2) begin errors++; $display("FAIL b2b_word2: got %h want %h", cap_tx, W_2); end
  endtask

  task automatic test_reset_mid();
    int   k, n, rxv;
    logic pc;
    k = 0; n = 0; pc = c4; rxv = 0;
    do begin
      @(negedge clk50); n++;
      if (c4 && !pc) k++;
      pc = c4;
    end while (k < 21 && n < 2 * FRAME_CYC);
    reset = 1'b1;
    @(negedge clk50);
    rxv += rx_valid;
    checks++; if (c4 !== 1'b0) begin errors++; $display("FAIL mid_rst_c4: got %b want 0", c4); end
    checks++; if (f0 !== 1'b1) begin errors++; $display("FAIL mid_rst_f0: got %b want 1", f0); end
    checks++; if (data_to_conv !== 1'b0) begin errors++; $display("FAIL mid_rst_dout: got %b want 0", data_to_conv); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", tx_ready); end
    repeat (3) begin @(negedge clk50); rxv += rx_valid; end
    reset = 1'b0;
    n = 0;
    do begin @(negedge clk50); n++; rxv += rx_valid; end while (!frame_start && n < 100);
    checks++; if (n !== 2 * HALF + 1) begin errors++; $display("FAIL restart_fs_delay: got %0d want %0d", n, 2 * HALF + 1); end
    checks++; if (rxv !== 0) begin errors++; $display("FAIL partial_rx_valid: got %0d want 0", rxv); end
    capture_frame();
    checks++; if (cap_rxv !== 1) begin errors++; $display("FAIL restart_rx_count: got %0d want 1", cap_rxv); end
    checks++; if (cap_rx !== IDLE_W) begin errors++; $display("FAIL restart_rx_word: got %h want %h", cap_rx, IDLE_W); end
  endtask

  task automatic test_disable();
    int act;
    enable = 1'b0;
    repeat (2 * HALF + 2) @(negedge clk50);
    act = 0;
    repeat (40) begin
      @(negedge clk50);
      if (c4 || !f0 || data_to_conv || frame_start) act++;
    end
    checks++; if (act !== 0) begin errors++; $display("FAIL bus_idle: got %0d active cycles want 0", act); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; tx_valid = 1'b0; tx_data = '0;
    test_reset();
    test_framing();
    test_tx_loopback();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    test_disable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
